// File: rtl/clk_div_pkg.sv
// Shared constants, ratio type and ratio helpers for the programmable clock divider.
package clk_div_pkg;

    localparam int RATIO_W   = 8;
    localparam int RATIO_MIN = 2;

    typedef logic [RATIO_W-1:0] ratio_t;

    function automatic logic is_odd(input logic [31:0] ratio);
        return ratio[0];
    endfunction

    // Number of posedge-registered high cycles; odd ratios gain the extra half cycle from the negedge phase.
    function automatic logic [31:0] half_cnt(input logic [31:0] ratio);
        return ratio >> 32'd1;
    endfunction

endpackage

// File: rtl/clk_div_if.sv
// Control/status bundle for all divider channels.
interface clk_div_if #(
    parameter int NUM_CH = 2,
    parameter int W      = 8
);
    logic [NUM_CH-1:0]        en;
    logic [NUM_CH-1:0][W-1:0] div_ratio;
    logic [NUM_CH-1:0]        div_load;
    logic [NUM_CH-1:0]        div_busy;
    logic [NUM_CH-1:0]        div_err;
    logic [NUM_CH-1:0]        clk_out;
    logic [NUM_CH-1:0]        tick;

    modport master (
        output en, div_ratio, div_load,
        input  div_busy, div_err, clk_out, tick
    );

    modport slave (
        input  en, div_ratio, div_load,
        output div_busy, div_err, clk_out, tick
    );
endinterface

// File: rtl/clk_div_ch.sv
// One divider channel: period counter, shadow ratio, run flag and posedge/negedge phase registers.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int W             = 8,
    parameter int DEFAULT_RATIO = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] div_ratio,
    input  logic         div_load,
    output logic         div_busy,
    output logic         div_err,
    output logic         clk_out,
    output logic         tick
);

    typedef logic [W-1:0] ratio_t;

    localparam ratio_t DEF_R    = ratio_t'(DEFAULT_RATIO);
    localparam ratio_t DEF_HALF = ratio_t'(half_cnt(32'(DEFAULT_RATIO)));
    localparam logic   DEF_ODD  = is_odd(32'(DEFAULT_RATIO));
    localparam ratio_t ONE_R    = ratio_t'(1);

    ratio_t ratio_r;
    ratio_t shadow_r;
    ratio_t cnt_r;
    ratio_t half_r;
    logic   odd_r;
    logic   busy_r;
    logic   err_r;
    logic   run_r;
    logic   pos_r;
    logic   neg_r;
    logic   tick_r;

    logic   boundary_s;
    logic   load_ok_s;
    ratio_t next_n_s;
    ratio_t cnt_inc_s;

    // Boundary detection and load qualification.
    always_comb begin
        boundary_s = (cnt_r == (ratio_r - ONE_R));
        load_ok_s  = div_load && (div_ratio >= ratio_t'(RATIO_MIN));
        next_n_s   = busy_r ? shadow_r : ratio_r;
        cnt_inc_s  = cnt_r + ONE_R;
    end

    // Period counter, ratio/mode latch and posedge phase; an idle channel parks at N-1 so every edge is a boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ratio_r <= DEF_R;
            half_r  <= DEF_HALF;
            odd_r   <= DEF_ODD;
            cnt_r   <= DEF_R - ONE_R;
            run_r   <= 1'b0;
            tick_r  <= 1'b0;
            pos_r   <= 1'b0;
        end else if (boundary_s) begin
            ratio_r <= next_n_s;
            half_r  <= ratio_t'(half_cnt(32'(next_n_s)));
            odd_r   <= is_odd(32'(next_n_s));
            cnt_r   <= en ? {W{1'b0}} : (next_n_s - ONE_R);
            run_r   <= en;
            tick_r  <= en;
            pos_r   <= en;
        end else begin
            cnt_r   <= cnt_inc_s;
            tick_r  <= 1'b0;
            pos_r   <= run_r && (cnt_inc_s < half_r);
        end
    end

    // Shadow ratio, pending flag and reject pulse; a load on a boundary edge waits for the next boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_r <= DEF_R;
            busy_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            err_r <= div_load && !load_ok_s;
            if (load_ok_s) begin
                shadow_r <= div_ratio;
                busy_r   <= 1'b1;
            end else if (boundary_s) begin
                busy_r   <= 1'b0;
            end else begin
                busy_r   <= busy_r;
            end
        end
    end

    // Half-cycle delayed copy of the posedge phase, used to stretch odd-ratio high time.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_r <= 1'b0;
        end else begin
            neg_r <= pos_r;
        end
    end

    assign clk_out  = odd_r ? (pos_r | neg_r) : pos_r;
    assign tick     = tick_r;
    assign div_busy = busy_r;
    assign div_err  = err_r;

endmodule

// File: rtl/clk_div_prog.sv
// Multi-channel programmable 50%-duty clock divider built from independent channels.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int W             = 8,
    parameter int NUM_CH        = 2,
    parameter int DEFAULT_RATIO = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    clk_div_if.slave  bus
);

    typedef logic [W-1:0] ratio_t;

    logic [NUM_CH-1:0] busy_s;
    logic [NUM_CH-1:0] err_s;
    logic [NUM_CH-1:0] clk_out_s;
    logic [NUM_CH-1:0] tick_s;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_ch #(
            .W             (W),
            .DEFAULT_RATIO (DEFAULT_RATIO)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (bus.en[i]),
            .div_ratio (bus.div_ratio[i]),
            .div_load  (bus.div_load[i]),
            .div_busy  (busy_s[i]),
            .div_err   (err_s[i]),
            .clk_out   (clk_out_s[i]),
            .tick      (tick_s[i])
        );
    end

    assign bus.div_busy = busy_s;
    assign bus.div_err  = err_s;
    assign bus.clk_out  = clk_out_s;
    assign bus.tick     = tick_s;

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: directed and random steps checked against a half-cycle waveform model.
module tb_clk_div_prog;

    localparam int NUM_CH = 2;
    localparam int W      = 8;
    localparam int DEF    = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    clk_div_if #(.NUM_CH(NUM_CH), .W(W)) bus ();

    clk_div_prog #(.W(W), .NUM_CH(NUM_CH), .DEFAULT_RATIO(DEF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: a period of ratio N spans 2N half-cycles, the first N of them high.
    int m_n    [NUM_CH];
    int m_sh   [NUM_CH];
    int m_el   [NUM_CH];
    bit m_pend [NUM_CH];
    bit m_run  [NUM_CH];
    bit m_err  [NUM_CH];
    bit m_tick [NUM_CH];

    task automatic chk(input string tag, input int ch, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s ch%0d t=%0t observed=%b expected=%b", tag, ch, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_n[c]    = DEF;
            m_sh[c]   = DEF;
            m_el[c]   = 0;
            m_pend[c] = 1'b0;
            m_run[c]  = 1'b0;
            m_err[c]  = 1'b0;
            m_tick[c] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int c = 0; c < NUM_CH; c++) begin
            if (!m_run[c] || (m_el[c] == m_n[c] - 1)) begin
                if (m_pend[c]) begin
                    m_n[c]    = m_sh[c];
                    m_pend[c] = 1'b0;
                end
                m_run[c]  = bus.en[c];
                m_el[c]   = 0;
                m_tick[c] = bus.en[c];
            end else begin
                m_el[c]   = m_el[c] + 1;
                m_tick[c] = 1'b0;
            end
            m_err[c] = 1'b0;
            if (bus.div_load[c]) begin
                if (int'(bus.div_ratio[c]) >= 2) begin
                    m_sh[c]   = int'(bus.div_ratio[c]);
                    m_pend[c] = 1'b1;
                end else begin
                    m_err[c] = 1'b1;
                end
            end
        end
    endtask

    function automatic logic exp_out(input int c, input int half);
        return m_run[c] && ((2 * m_el[c] + half) < m_n[c]);
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #2;
        for (int c = 0; c < NUM_CH; c++) begin
            chk("clk_out_hi_phase", c, bus.clk_out[c], exp_out(c, 0));
            chk("tick", c, bus.tick[c], m_tick[c]);
            chk("busy", c, bus.div_busy[c], m_pend[c]);
            chk("err", c, bus.div_err[c], m_err[c]);
        end
        @(negedge clk);
        #2;
        for (int c = 0; c < NUM_CH; c++) begin
            chk("clk_out_lo_phase", c, bus.clk_out[c], exp_out(c, 1));
        end
        bus.div_load = '0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic load(input int c, input int val);
        bus.div_load[c]  = 1'b1;
        bus.div_ratio[c] = W'(val);
    endtask

    // Advance until the next posedge is a boundary of channel c.
    task automatic wait_boundary(input int c);
        logic found;
        found = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (!m_run[c] || (m_el[c] == m_n[c] - 1)) begin
                found = 1'b1;
                break;
            end
            cycle();
        end
        chk("wait_boundary_timeout", c, found, 1'b1);
    endtask

    initial begin
        bus.en        = '0;
        bus.div_load  = '0;
        bus.div_ratio = '0;
        model_reset();

        #12;
        for (int c = 0; c < NUM_CH; c++) begin
            chk("rst_clk_out", c, bus.clk_out[c], 1'b0);
            chk("rst_tick", c, bus.tick[c], 1'b0);
            chk("rst_busy", c, bus.div_busy[c], 1'b0);
            chk("rst_err", c, bus.div_err[c], 1'b0);
        end

        @(negedge clk);
        rst_n  = 1'b1;
        bus.en = '1;
        run(12);

        load(0, 3); cycle(); run(12);
        load(0, 5); cycle(); run(16);
        load(0, 4); cycle(); run(10);

        wait_boundary(0); cycle(); cycle();
        load(0, 6); cycle(); run(16);

        load(0, 1); cycle();
        load(0, 0); cycle(); run(10);

        load(0, 7); cycle();
        load(0, 9); cycle(); run(30);

        wait_boundary(0);
        load(0, 5); cycle(); run(25);

        wait_boundary(0); cycle();
        bus.en[0] = 1'b0; run(14);
        load(0, 3); cycle(); run(3);
        bus.en[0] = 1'b1; run(10);
        load(0, 4); cycle(); run(8);

        // Reset while ch0 is high with a load pending.
        wait_boundary(0); cycle();
        load(0, 7); cycle();
        rst_n = 1'b0;
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            chk("midrst_clk_out", c, bus.clk_out[c], 1'b0);
            chk("midrst_busy", c, bus.div_busy[c], 1'b0);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run(12);

        load(0, 3); load(1, 8); cycle(); run(50);

        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 7) == 0) load(c, int'($urandom_range(0, 12)));
                if ($urandom_range(0, 19) == 0) bus.en[c] = ~bus.en[c];
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
